lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store unit that acts as the initiator on the data-memory port of the multi-cycle RISC-V core. It accepts one load or store at a time from the core's MEM stage and converts RV32I byte, halfword and word accesses into word-wide reads and writes on the memory. The memory has a combinational read and a write on the clock edge. Sub-word loads are extracted and extended here. Sub-word stores are done as read-modify-write, and misaligned or out-of-range accesses are rejected with an error response.

## Interface
- MEM_WORDS, 256: number of 32-bit words in data memory; a word index at or above this value is out of range.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and for errors.
- resp_err  out  1  qualified by resp_valid; 1 = misaligned, illegal funct3, or out of range.
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  merged word to write.
- mem_write  out  1  write enable.
- mem_rdata  in  32  combinational read data for mem_addr.

## Operation
- States: IDLE, READ, WRITE, RESP.
- On accept, register addr, funct3, store flag and wdata. The request inputs are then ignored until the unit returns to IDLE.
- Error check at accept:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load funct3 3/6/7, or store funct3 >2.
  - Out of range: addr[31:2] >= MEM_WORDS.
- State transitions:
  - IDLE -> RESP if the error check fails. No memory access is made.
  - IDLE -> WRITE for SW.
  - IDLE -> READ for all loads and for SB/SH.
- READ: mem_addr is driven with the latched word address and mem_rdata is captured into an internal word register.
  - Loads: go to RESP.
  - SB/SH: go to WRITE.
- Load extraction is little-endian; byte offset k occupies bits [8k+7:8k].
  - LB/LH sign-extend the selected byte or halfword.
  - LBU/LHU zero-extend it.
  - LW passes the word through.
- WRITE: mem_write=1 for exactly one cycle, then go to RESP.
  - SW: mem_wdata = wdata.
  - SB/SH: mem_wdata = captured word with only the addressed byte or halfword replaced.
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_err, then go to IDLE. resp_rdata and resp_err hold their values until the next RESP.
- mem_write is decoded from the state and is 0 in every state except WRITE.
- mem_addr holds the last latched word address. mem_wdata is only meaningful in WRITE.

## Timing
- Reset values:
  - state IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_write=0, mem_addr=0, mem_wdata=0.
  - Internal registers 0.
- Latency is counted from the accepting edge E0 (edge E1 is the next rising edge, E2 the one after); the first cycle after E0 is cycle 1.
  - Error: resp_valid in cycle 1.
  - Load: READ in cycle 1, resp_valid in cycle 2.
  - SW: WRITE in cycle 1, resp_valid in cycle 2.
  - SB/SH: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
- The memory write occurs at the edge ending the WRITE cycle. The response follows one cycle later, so a load issued after resp_valid sees the new data.
- Back-to-back: req_ready returns high in the cycle after RESP. The maximum rate is one access per 2–4 cycles and nothing is pipelined.
- Reset asserted mid-operation:
  - State returns to IDLE immediately and mem_write drops asynchronously.
  - No partial write completes and no response is issued.
  - The aborted request is lost.
- req_valid held high during RESP is not accepted until IDLE.

## Test plan
- LB/LBU/LH: memory word at 0x100 = 0x8899AABB.
  - LB 0x101 -> 0xFFFFFFAA.
  - LBU 0x103 -> 0x00000088.
  - LH 0x102 -> 0xFFFF8899.
  - Each with resp_err=0 and resp_valid in cycle 2.
- SB/SH: word at 0x100 = 0x8899AABB.
  - SB 0x102 with wdata 0x12345677 -> one mem_write pulse in cycle 2 with mem_wdata=0x8877AABB; resp_valid in cycle 3.
  - Then SH 0x100 with wdata 0x00001234 -> word becomes 0x88771234.
- SW then LW: SW 0x200 with 0xDEADBEEF issued back-to-back with LW 0x200 -> LW returns 0xDEADBEEF; exactly one mem_write pulse for the SW.
- Errors, each -> resp_valid in cycle 1, resp_err=1, resp_rdata=0, mem_write never asserted:
  - LW 0x102.
  - SH 0x101.
  - Load with funct3=3.
  - LW 0x400 with MEM_WORDS=256.
- Reset in the WRITE state of an SB -> mem_write falls with reset, the memory word is unchanged, no resp_valid, and req_ready=1 after release.
- Stall: req_valid held high continuously with changing addr -> only the address sampled at each req_ready edge is used; the request count equals the resp_valid count.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit on the data-memory port: turns RV32I byte/halfword/word accesses into
// word-wide memory reads and writes; sub-word stores use read-modify-write.
module lsu_mem_port #(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              store_q, store_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              req_ready_d, resp_valid_d, resp_err_d, mem_write_d;
   logic [XLEN-1:0]   resp_rdata_d, mem_addr_d, mem_wdata_d;
   logic              acc_err_c;

   // Little-endian extraction with sign or zero extension
   function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] off);
      logic [XLEN-1:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'd0:    return {{24{sh[7]}}, sh[7:0]};
         3'd1:    return {{16{sh[15]}}, sh[15:0]};
         3'd4:    return {24'b0, sh[7:0]};
         3'd5:    return {16'b0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] word,
                                                   input logic [15:0] data,
                                                   input logic byte_op,
                                                   input logic [1:0] off);
      logic [XLEN-1:0] mask, ins;
      if (byte_op) begin
         mask = 32'h0000_00FF << {off, 3'b000};
         ins  = {24'b0, data[7:0]} << {off, 3'b000};
      end else begin
         mask = 32'h0000_FFFF << {off[1], 4'b0000};
         ins  = {16'b0, data} << {off[1], 4'b0000};
      end
      return (word & ~mask) | ins;
   endfunction

   // Request rejection: illegal funct3, misalignment or word index out of range
   always_comb begin
      acc_err_c = 1'b0;
      if (req_store) begin
         if (req_funct3 > 3'd2) acc_err_c = 1'b1;
      end else begin
         if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) acc_err_c = 1'b1;
      end
      if (req_funct3[1:0] == 2'd1 && req_addr[0]) acc_err_c = 1'b1;
      if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) acc_err_c = 1'b1;
      if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) acc_err_c = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      funct3_d     = funct3_q;
      store_d      = store_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      mem_write_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               off_d      = req_addr[1:0];
               funct3_d   = req_funct3;
               store_d    = req_store;
               wdata_d    = req_wdata[15:0];
               mem_addr_d = {req_addr[31:2], 2'b00};
               if (acc_err_c) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = '0;
                  resp_err_d   = 1'b1;
               end else if (req_store && req_funct3 == 3'd2) begin
                  state_d     = WRITE;
                  mem_write_d = 1'b1;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (store_q) begin
               state_d     = WRITE;
               mem_write_d = 1'b1;
               mem_wdata_d = store_merge(mem_rdata, wdata_q, funct3_q[1:0] == 2'd0, off_q);
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extract(mem_rdata, funct3_q, off_q);
               resp_err_d   = 1'b0;
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         off_q      <= '0;
         funct3_q   <= '0;
         store_q    <= 1'b0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_write  <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         funct3_q   <= funct3_d;
         store_q    <= store_d;
         wdata_q    <= wdata_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         mem_write  <= mem_write_d;
      end
   end

endmodule
